// File: rtl/riscv_pkg.sv
// Shared RV32I core definitions: architectural widths, reset defaults and
// the IF/ID pipeline register layout.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            valid;
  } if_id_t;

  localparam if_id_t IF_ID_FLUSH = '{
    instr:    NOP_INSTR,
    pc:       '0,
    pc_plus4: '0,
    valid:    1'b0
  };

endpackage

// File: rtl/pc_reg.sv
// Program counter register with redirect/stall next-PC selection, word
// alignment of redirect targets and a one-cycle misaligned-target pulse.
module pc_reg
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_target_i,
  output logic [XLEN-1:0] pc_o,
  output logic            misaligned_o
);

  logic [XLEN-1:0] pc_q;
  logic            misaligned_q;

  // Redirect wins over stall; the low two target bits are dropped so fetch
  // always continues on a word boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      misaligned_q <= 1'b0;
    end else begin
      misaligned_q <= redirect_i && (redirect_target_i[1:0] != 2'b00);
      if (redirect_i) begin
        pc_q <= {redirect_target_i[XLEN-1:2], 2'b00};
      end else if (!stall_i) begin
        pc_q <= pc_q + 32'd4;
      end
    end
  end

  assign pc_o         = pc_q;
  assign misaligned_o = misaligned_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: drives the PC to instruction memory, captures the
// returned instruction into the IF/ID register and counts captured fetches.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0]  RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned  DATA_WIDTH = 32,
  parameter int unsigned  CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_i,
  input  logic                  redirect_i,
  input  logic [31:0]           redirect_target_i,
  output logic [31:0]           pc_o,
  input  logic [DATA_WIDTH-1:0] instr_i,
  output logic [DATA_WIDTH-1:0] if_id_instr_o,
  output logic [31:0]           if_id_pc_o,
  output logic [31:0]           if_id_pc_plus4_o,
  output logic                  if_id_valid_o,
  output logic                  misaligned_o,
  output logic [CNT_WIDTH-1:0]  fetch_count_o
);

  if (DATA_WIDTH != XLEN) begin : g_width_check
    $error("fetch_stage: DATA_WIDTH must equal XLEN");
  end

  if_id_t               if_id_q;
  logic [CNT_WIDTH-1:0] fetch_count_q;

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk               (clk),
    .rst               (rst),
    .stall_i           (stall_i),
    .redirect_i        (redirect_i),
    .redirect_target_i (redirect_target_i),
    .pc_o              (pc_o),
    .misaligned_o      (misaligned_o)
  );

  // A redirect flushes the instruction fetched this cycle, so it is neither
  // captured nor counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_id_q       <= IF_ID_FLUSH;
      fetch_count_q <= '0;
    end else if (redirect_i) begin
      if_id_q <= IF_ID_FLUSH;
    end else if (!stall_i) begin
      if_id_q <= '{
        instr:    instr_i,
        pc:       pc_o,
        pc_plus4: pc_o + 32'd4,
        valid:    1'b1
      };
      fetch_count_q <= fetch_count_q + CNT_WIDTH'(1);
    end
  end

  assign if_id_instr_o    = if_id_q.instr;
  assign if_id_pc_o       = if_id_q.pc;
  assign if_id_pc_plus4_o = if_id_q.pc_plus4;
  assign if_id_valid_o    = if_id_q.valid;
  assign fetch_count_o    = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a behavioural fetch model pushes the
// expected post-edge state per cycle, which is popped and compared after it.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_target_i;
  logic [31:0] pc_o;
  logic [31:0] instr_i;
  logic [31:0] if_id_instr_o;
  logic [31:0] if_id_pc_o;
  logic [31:0] if_id_pc_plus4_o;
  logic        if_id_valid_o;
  logic        misaligned_o;
  logic [31:0] fetch_count_o;

  fetch_stage #(
    .RESET_PC   (32'h0000_0000),
    .DATA_WIDTH (32),
    .CNT_WIDTH  (32)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .stall_i           (stall_i),
    .redirect_i        (redirect_i),
    .redirect_target_i (redirect_target_i),
    .pc_o              (pc_o),
    .instr_i           (instr_i),
    .if_id_instr_o     (if_id_instr_o),
    .if_id_pc_o        (if_id_pc_o),
    .if_id_pc_plus4_o  (if_id_pc_plus4_o),
    .if_id_valid_o     (if_id_valid_o),
    .misaligned_o      (misaligned_o),
    .fetch_count_o     (fetch_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [31:0] a);
    logic [31:0] w;
    if (a == 32'h0)      w = 32'h0050_0093;
    else if (a == 32'h4) w = 32'h0010_0113;
    else                 w = {a[31:2], 2'b11} ^ 32'h5A00_0000;
    return w;
  endfunction

  assign instr_i = imem(pc_o);

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] ipc;
    logic [31:0] p4;
    logic        valid;
    logic        mis;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  exp_t m;
  int   n_tests;
  int   n_fail;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m = '{pc: 32'h0, instr: 32'h0000_0013, ipc: 32'h0, p4: 32'h0,
          valid: 1'b0, mis: 1'b0, cnt: 32'h0};
  endtask

  task automatic compare_state(input exp_t e, input string pfx);
    check({pfx, ".pc"},    pc_o,                 e.pc);
    check({pfx, ".instr"}, if_id_instr_o,        e.instr);
    check({pfx, ".ipc"},   if_id_pc_o,           e.ipc);
    check({pfx, ".p4"},    if_id_pc_plus4_o,     e.p4);
    check({pfx, ".valid"}, 32'(if_id_valid_o),   32'(e.valid));
    check({pfx, ".mis"},   32'(misaligned_o),    32'(e.mis));
    check({pfx, ".cnt"},   fetch_count_o,        e.cnt);
  endtask

  // Drive one cycle, predict the post-edge state, then compare after the edge.
  task automatic cycle(input logic st, input logic rd, input logic [31:0] tgt);
    exp_t e;
    stall_i           = st;
    redirect_i        = rd;
    redirect_target_i = tgt;
    e = m;
    e.mis = rd && (tgt[1:0] != 2'b00);
    if (rd) begin
      e.pc    = {tgt[31:2], 2'b00};
      e.instr = 32'h0000_0013;
      e.ipc   = 32'h0;
      e.p4    = 32'h0;
      e.valid = 1'b0;
    end else if (!st) begin
      e.instr = imem(m.pc);
      e.ipc   = m.pc;
      e.p4    = m.pc + 32'd4;
      e.valid = 1'b1;
      e.cnt   = m.cnt + 32'd1;
      e.pc    = m.pc + 32'd4;
    end
    m = e;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_underflow", 32'd0, 32'd1);
    end else begin
      compare_state(sb.pop_front(), "sb");
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    stall_i = 1'b0;
    redirect_i = 1'b0;
    redirect_target_i = 32'h0;
    model_reset();
    #12;
    compare_state(m, "reset");
    rst = 1'b0;
    #1;
    check("post_rst_pc", pc_o, 32'h0);

    // First capture from RESET_PC.
    cycle(1'b0, 1'b0, 32'h0);
    check("first_instr", if_id_instr_o, 32'h0050_0093);
    check("first_pc4", if_id_pc_plus4_o, 32'h4);
    check("first_pc", pc_o, 32'h4);
    cycle(1'b0, 1'b0, 32'h0);
    check("second_instr", if_id_instr_o, 32'h0010_0113);

    // Stall for three cycles at pc 8.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h0);
    check("stall_pc", pc_o, 32'h8);
    check("stall_cnt", fetch_count_o, 32'd2);
    cycle(1'b0, 1'b0, 32'h0);
    check("after_stall_ipc", if_id_pc_o, 32'h8);

    // Redirect to 0x40 from 0x10.
    cycle(1'b0, 1'b0, 32'h0);
    check("pre_redirect_pc", pc_o, 32'h10);
    cycle(1'b0, 1'b1, 32'h40);
    check("redir_pc", pc_o, 32'h40);
    check("redir_valid", 32'(if_id_valid_o), 32'd0);
    cycle(1'b0, 1'b0, 32'h0);
    check("redir_ipc", if_id_pc_o, 32'h40);

    // Redirect beats stall; misaligned target.
    cycle(1'b1, 1'b1, 32'h22);
    check("mis_pc", pc_o, 32'h20);
    check("mis_pulse", 32'(misaligned_o), 32'd1);
    cycle(1'b0, 1'b0, 32'h0);
    check("mis_clear", 32'(misaligned_o), 32'd0);

    // PC wraparound.
    cycle(1'b0, 1'b1, 32'hFFFF_FFFC);
    cycle(1'b0, 1'b0, 32'h0);
    check("wrap_pc", pc_o, 32'h0);
    check("wrap_p4", if_id_pc_plus4_o, 32'h0);
    check("wrap_ipc", if_id_pc_o, 32'hFFFF_FFFC);

    // Mixed random traffic.
    for (int i = 0; i < 60; i++) begin
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, $urandom());
    end

    // Asynchronous reset mid-cycle during a redirect.
    stall_i = 1'b0;
    redirect_i = 1'b1;
    redirect_target_i = 32'h80;
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    compare_state(m, "async_rst");
    #2;
    rst = 1'b0;
    redirect_i = 1'b0;
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 32'h0);
    check("rst_recover_cnt", fetch_count_o, 32'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the pipelined RV32I core, directly upstream of the byte-addressed instruction memory.
- Owns the program counter and drives it to the memory's PC input. The memory returns a 32-bit little-endian instruction combinationally.
- Captures that instruction into the IF/ID pipeline register for decode.
- Handles stall from the hazard unit, redirect/flush from the execute stage, and counts fetched instructions.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- DATA_WIDTH, 32, instruction width; must match the instruction memory.
- CNT_WIDTH, 32, width of the fetched-instruction counter.

Ports:
- clk  in  1  core clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- stall_i  in  1  hazard unit: hold PC and IF/ID contents.
- redirect_i  in  1  EX stage: branch taken / jump; load new PC and flush IF/ID.
- redirect_target_i  in  32  new PC when redirect_i=1.
- pc_o  out  32  current PC, wired to instruction memory PC input.
- instr_i  in  DATA_WIDTH  instruction from memory for pc_o, same cycle.
- if_id_instr_o  out  DATA_WIDTH  registered instruction to decode.
- if_id_pc_o  out  32  registered PC of if_id_instr_o.
- if_id_pc_plus4_o  out  32  registered PC+4, used for JAL/JALR link.
- if_id_valid_o  out  1  IF/ID holds a real instruction.
- misaligned_o  out  1  one-cycle registered pulse: last redirect target had [1:0]!=0.
- fetch_count_o  out  CNT_WIDTH  number of instructions captured into IF/ID.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - pc_o=RESET_PC.
  - if_id_instr_o=NOP (32'h0000_0013).
  - if_id_pc_o=0, if_id_pc_plus4_o=0.
  - if_id_valid_o=0, misaligned_o=0, fetch_count_o=0.
- pc_o is a register output, never a combinational path from the inputs.
- Next-PC priority, evaluated at each rising edge:
  1. redirect_i=1: pc <= {redirect_target_i[31:2],2'b00}.
  2. else stall_i=1: pc holds.
  3. else: pc <= pc+4.
- Redirect always beats stall when both are asserted in the same cycle.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 = 32'h0000_0000, with no flag.
- IF/ID register update, same priority order:
  - redirect_i=1 (flush): instr<=NOP, pc<=0, pc_plus4<=0, valid<=0. The instruction being fetched this cycle is discarded; the counter does not increment.
  - else stall_i=1: all IF/ID fields and the counter hold.
  - else: instr<=instr_i, pc<=pc_o, pc_plus4<=pc_o+4, valid<=1, fetch_count<=fetch_count+1 (wraps at 2^CNT_WIDTH).
- Latency:
  - Instruction at address A appears on if_id_* one edge after pc_o=A, provided no stall or redirect occurs on that edge.
  - After a redirect edge, pc_o=target. if_id_valid_o=0 for that one cycle. The target instruction appears on the next unstalled edge.
- misaligned_o: set to 1 on an edge where redirect_i=1 and redirect_target_i[1:0]!=0; cleared to 0 on every other edge. Fetch continues at the word-aligned address.
- First cycle after reset deassertion:
  - pc_o=RESET_PC, if_id_valid_o=0.
  - The first unstalled edge captures the RESET_PC instruction.
- Reset asserted mid-stall or mid-redirect: reset overrides everything; state returns to reset values asynchronously.
- stall_i held for N cycles: PC and IF/ID hold for N edges. instr_i may be re-read; it is ignored.

Decomposition:
- Shared package riscv_pkg:
  - NOP_INSTR constant (32'h0000_0013).
  - RESET_PC default.
  - XLEN=32.
  - if_id_t packed struct {instr, pc, pc_plus4, valid}.
- One natural sub-module: pc_reg, containing the PC register, next-PC mux, alignment masking and misaligned pulse.
- The top level contains the IF/ID register and the counter.

Test Plan:
- Reset, then release, with memory holding 0x00500093 at 0 and 0x00100113 at 4 → pc_o=0, valid=0. After edge 1: if_id_instr=0x00500093, if_id_pc=0, pc_plus4=4, valid=1, pc_o=4, fetch_count=1.
- stall_i=1 for 3 cycles at pc_o=8 → pc_o stays 8, IF/ID unchanged, fetch_count unchanged. After release, the next edge gives if_id_pc=8.
- redirect_i=1 with target 0x40 while pc_o=0x10 → next cycle pc_o=0x40, valid=0, instr=NOP, count unchanged. The following edge gives if_id_pc=0x40, valid=1.
- redirect_i=1 and stall_i=1 together with target 0x22 → pc_o=0x20, misaligned_o=1 for exactly one cycle, valid=0.
- Preload PC near the top by redirecting to 0xFFFFFFFC, then run unstalled → pc_o becomes 0x00000000, and if_id_pc_plus4=0x00000000 for the 0xFFFFFFFC instruction.
- Assert rst asynchronously mid-cycle during a redirect → all outputs return to reset values before the next clock edge.
